// File: rtl/dma_burst_arbiter.sv
// dma_burst_arbiter
//   Shares one external-memory DMA port among N_MASTERS requesters. Arbitration is
//   round-robin at burst granularity: the winner owns the port for exactly len+1 beats,
//   after which priority moves to the master after the winner.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   m_valid/m_addr/   per-master request fields, master i in slice i
//   m_wdata/m_wstrb/  (wstrb all-zero means read)
//   m_len
//   m_rdata, m_ready  per-master read data and beat accept (only the owner sees s_*)
//   s_valid/s_addr/   DMA port request, driven from the owner; zero while idle
//   s_wdata/s_wstrb
//   s_len             burst length latched at grant
//   s_rdata, s_ready  DMA port read data and beat accept
//   grant             registered one-hot owner, zero while idle
//   busy              high while a burst is owned
module dma_burst_arbiter #(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned LEN_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    input  logic [N_MASTERS*LEN_W-1:0]    m_len,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic [LEN_W-1:0]              s_len,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int          N      = int'(N_MASTERS);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;

    logic [PTR_W-1:0]     owner;
    logic [N_MASTERS-1:0] pick;
    logic [LEN_W-1:0]     pick_len;
    logic                 found;
    logic                 beat;

    // Binary index of the current owner.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) owner = PTR_W'(i);
        end
    end

    // Round-robin scan: first requester at ptr, ptr+1, ... with wrap.
    always_comb begin
        pick     = '0;
        pick_len = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && m_valid[i] && ((int'(ptr_q) + k) % N) == i) begin
                    pick[i]  = 1'b1;
                    pick_len = m_len[i*LEN_W +: LEN_W];
                    found    = 1'b1;
                end
            end
        end
    end

    // Owner datapath; grant_q is zero while idle so everything falls back to 0.
    always_comb begin
        s_valid = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        m_ready = '0;
        m_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                s_valid                    = m_valid[i];
                s_addr                     = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata                    = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb                    = m_wstrb[i*STRB_W +: STRB_W];
                m_ready[i]                 = s_ready;
                m_rdata[i*DATA_W +: DATA_W] = s_rdata;
            end
        end
    end

    assign beat  = s_valid & s_ready;
    assign s_len = len_q;
    assign grant = grant_q;
    assign busy  = (state_q == StBurst);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBurst;
                    grant_d = pick;
                    len_d   = pick_len;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (beat) begin
                    // Compare before incrementing so a full-range length never wraps.
                    if (cnt_q == len_q) begin
                        state_d = StIdle;
                        grant_d = '0;
                        ptr_d   = (owner == PTR_W'(N - 1)) ? '0 : owner + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dma_burst_arbiter.sv
module tb_dma_burst_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int LW = 8;
    localparam int CW = N * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N*LW-1:0]   m_len;
    logic [N*DW-1:0]   m_rdata;
    logic [N-1:0]      m_ready;
    logic              s_valid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [LW-1:0]     s_len;
    logic [DW-1:0]     s_rdata;
    logic              s_ready;
    logic [N-1:0]      grant;
    logic              busy;

    always #5 clk = ~clk;

    dma_burst_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_len(m_len), .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_len(s_len), .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .busy(busy)
    );

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [CW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks   = 0;
    int            failures = 0;
    int            beat_cnt = 0;
    int            cyc      = 0;
    int            beat_cyc[$];
    int            b;
    logic [DW-1:0] rd_pat;

    task automatic check_w(input string name, input logic [CW-1:0] got,
                           input logic [CW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_i(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [LW-1:0] l);
        m_valid[i]          = v;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_wstrb[i*SW +: SW] = s;
        m_len[i*LW +: LW]   = l;
    endtask

    task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s);
        exp_t e;
        e.grant    = '0;
        e.grant[i] = 1'b1;
        e.addr     = a;
        e.wdata    = d;
        e.wstrb    = s;
        e.rdata    = '0;
        e.rdata[i*DW +: DW] = rd_pat;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until the monitor has seen `target` beats; optionally toggle s_ready.
    task automatic run_until(input string name, input int target, input int budget,
                             input bit toggle);
        int n = 0;
        while (beat_cnt < target && n < budget) begin
            tick();
            if (toggle) s_ready = ~s_ready;
            n++;
        end
        if (beat_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL %s: beats=%0d want=%0d (timeout)", name, beat_cnt, target);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every accepted beat is matched against the next expectation.
    always @(negedge clk) begin
        if (rst && s_valid && s_ready) begin
            beat_cnt++;
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: grant=%b addr=%h, no beat expected", grant,
                         s_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check_i("beat_grant", int'(grant), int'(mon_e.grant));
                check_i("beat_m_ready", int'(m_ready), int'(mon_e.grant));
                check_w("beat_addr", CW'(s_addr), CW'(mon_e.addr));
                check_w("beat_wdata", CW'(s_wdata), CW'(mon_e.wdata));
                check_w("beat_wstrb", CW'(s_wstrb), CW'(mon_e.wstrb));
                check_w("beat_m_rdata", m_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        m_len   = '0;
        s_ready = 1'b0;
        rd_pat  = {32{8'hA5}};
        s_rdata = rd_pat;

        // Reset state
        repeat (2) @(negedge clk);
        check_i("rst_grant", int'(grant), 0);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_s_valid", int'(s_valid), 0);
        check_i("rst_s_len", int'(s_len), 0);
        check_i("rst_m_ready", int'(m_ready), 0);
        check_w("rst_m_rdata", m_rdata, '0);
        check_w("rst_s_addr", CW'(s_addr), '0);
        tick();
        rst = 1'b1;
        tick();

        // Test 1: single master 1, len=3
        s_ready = 1'b1;
        b = beat_cnt;
        set_m(1, 1'b1, 32'h0000_1100, {8{32'h1111_0000}}, '0, 8'd3);
        for (int k = 0; k < 4; k++) push(1, 32'h0000_1100, {8{32'h1111_0000}}, '0);
        @(negedge clk);
        check_i("t1_grant_before_edge", int'(grant), 0);
        tick();
        @(negedge clk);
        check_i("t1_grant", int'(grant), 3'b010);
        check_i("t1_busy", int'(busy), 1);
        check_i("t1_s_len", int'(s_len), 3);
        run_until("t1_beats", b + 4, 20, 1'b0);
        set_m(1, 1'b0, '0, '0, '0, 8'd0);
        @(negedge clk);
        check_i("t1_idle_grant", int'(grant), 0);
        check_i("t1_idle_busy", int'(busy), 0);
        check_i("t1_idle_s_valid", int'(s_valid), 0);
        check_w("t1_idle_s_addr", CW'(s_addr), '0);
        tick();
        check_i("t1_beat_total", beat_cnt, b + 4);
        // Pointer now at 2: master 2 beats master 0
        set_m(0, 1'b1, 32'h0000_0A00, '0, '0, 8'd0);
        set_m(2, 1'b1, 32'h0000_2A00, '0, '0, 8'd0);
        push(2, 32'h0000_2A00, '0, '0);
        run_until("t1_ptr", b + 5, 20, 1'b0);
        set_m(0, 1'b0, '0, '0, '0, 8'd0);
        set_m(2, 1'b0, '0, '0, '0, 8'd0);
        tick();

        // Test 2: all three request continuously, len=0
        b = beat_cnt;
        for (int i = 0; i < N; i++) set_m(i, 1'b1, AW'(32'h200 + i), '0, '0, 8'd0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, AW'(32'h200 + i), '0, '0);
        run_until("t2_beats", b + 6, 40, 1'b0);
        for (int i = 0; i < N; i++) set_m(i, 1'b0, '0, '0, '0, 8'd0);
        for (int k = 1; k < 6; k++)
            check_i("t2_spacing", beat_cyc[b + k] - beat_cyc[b + k - 1], 2);
        tick();

        // Test 3: master 0 write len=7 with s_ready toggling, master 2 waiting
        b = beat_cnt;
        s_ready = 1'b1;
        set_m(0, 1'b1, 32'h0000_3000, {8{32'hDEAD_0000}}, '1, 8'd7);
        set_m(2, 1'b1, 32'h0000_3200, {8{32'h0000_BEEF}}, 32'h0000_FFFF, 8'd0);
        for (int k = 0; k < 8; k++) push(0, 32'h0000_3000, {8{32'hDEAD_0000}}, '1);
        push(2, 32'h0000_3200, {8{32'h0000_BEEF}}, 32'h0000_FFFF);
        run_until("t3_m0_beats", b + 8, 100, 1'b1);
        set_m(0, 1'b0, '0, '0, '0, 8'd0);
        run_until("t3_m2_beat", b + 9, 20, 1'b1);
        set_m(2, 1'b0, '0, '0, '0, 8'd0);
        s_ready = 1'b1;
        tick();

        // Test 4: read burst from master 2, len=1
        b = beat_cnt;
        set_m(2, 1'b1, 32'h0000_4000, '0, '0, 8'd1);
        push(2, 32'h0000_4000, '0, '0);
        push(2, 32'h0000_4000, '0, '0);
        run_until("t4_beats", b + 2, 20, 1'b0);
        set_m(2, 1'b0, '0, '0, '0, 8'd0);
        tick();

        // Test 5: master 1 stalls for 5 cycles mid-burst; m_len change ignored
        b = beat_cnt;
        set_m(1, 1'b1, 32'h0000_5000, {8{32'h5555_5555}}, '1, 8'd3);
        for (int k = 0; k < 4; k++) push(1, 32'h0000_5000, {8{32'h5555_5555}}, '1);
        run_until("t5_first_beats", b + 2, 20, 1'b0);
        set_m(1, 1'b0, 32'h0000_5000, {8{32'h5555_5555}}, '1, 8'h55);
        repeat (5) begin
            @(negedge clk);
            check_i("t5_stall_grant", int'(grant), 3'b010);
        end
        check_i("t5_stall_beats", beat_cnt, b + 2);
        check_i("t5_s_len_held", int'(s_len), 3);
        tick();
        set_m(1, 1'b1, 32'h0000_5000, {8{32'h5555_5555}}, '1, 8'h55);
        run_until("t5_rest_beats", b + 4, 20, 1'b0);
        set_m(1, 1'b0, '0, '0, '0, 8'd0);
        @(negedge clk);
        check_i("t5_done_busy", int'(busy), 0);
        tick();
        check_i("t5_beat_total", beat_cnt, b + 4);

        // Test 6: reset mid-burst (after beat 2 of 8), then master 0 wins
        b = beat_cnt;
        set_m(2, 1'b1, 32'h0000_6000, '0, '0, 8'd7);
        push(2, 32'h0000_6000, '0, '0);
        push(2, 32'h0000_6000, '0, '0);
        run_until("t6_pre_reset", b + 2, 20, 1'b0);
        rst = 1'b0;
        #1;
        check_i("t6_rst_s_valid", int'(s_valid), 0);
        check_i("t6_rst_grant", int'(grant), 0);
        check_i("t6_rst_busy", int'(busy), 0);
        check_i("t6_rst_m_ready", int'(m_ready), 0);
        check_i("t6_rst_queue", exp_q.size(), 0);
        set_m(2, 1'b0, '0, '0, '0, 8'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        b = beat_cnt;
        for (int i = 0; i < N; i++) set_m(i, 1'b1, AW'(32'h600 + i), '0, '0, 8'd0);
        push(0, AW'(32'h600), '0, '0);
        run_until("t6_after_reset", b + 1, 20, 1'b0);
        for (int i = 0; i < N; i++) set_m(i, 1'b0, '0, '0, '0, 8'd0);
        tick();

        // Test 7: full-range length 255 -> 256 beats
        b = beat_cnt;
        set_m(1, 1'b1, 32'h0000_7000, {8{32'h7777_0001}}, '1, 8'hFF);
        for (int k = 0; k < 256; k++) push(1, 32'h0000_7000, {8{32'h7777_0001}}, '1);
        run_until("t7_beats", b + 256, 400, 1'b0);
        set_m(1, 1'b0, '0, '0, '0, 8'd0);
        @(negedge clk);
        check_i("t7_done_busy", int'(busy), 0);
        tick();
        check_i("t7_beat_total", beat_cnt, b + 256);

        check_i("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_burst_arbiter.md
Name: dma_burst_arbiter

Overview:
- Shares the single external-memory DMA native port (ext_mem databus plus dma_len) among N_MASTERS Versat data-bus requesters.
- Arbitrates round-robin at burst granularity: a granted master owns the port for exactly len+1 beats.
- After the burst completes, priority rotates to the next master.
- Sits between the Versat databus outputs and ext_mem in the USE_DDR / USE_NEW_VERSAT configuration.

Parameters:
- N_MASTERS, 3, number of requesters (2..8).
- ADDR_W, 32, byte address width (IO_ADDR_W).
- DATA_W, 256, beat data width (MIG_BUS_W); strobe width DATA_W/8.
- LEN_W, 8, burst length field width (AXI_LEN_W); beats = len+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- m_valid  in  N_MASTERS  per-master request/beat valid.
- m_addr  in  N_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  per-master write data.
- m_wstrb  in  N_MASTERS*DATA_W/8  per-master strobes; all-zero = read.
- m_len  in  N_MASTERS*LEN_W  per-master burst length minus one.
- m_rdata  out  N_MASTERS*DATA_W  per-master read data.
- m_ready  out  N_MASTERS  per-master beat accept.
- s_valid  out  1  DMA port valid.
- s_addr  out  ADDR_W  DMA port address.
- s_wdata  out  DATA_W  DMA port write data.
- s_wstrb  out  DATA_W/8  DMA port strobes.
- s_len  out  LEN_W  DMA port burst length (latched).
- s_rdata  in  DATA_W  DMA port read data.
- s_ready  in  1  DMA port beat accept.
- grant  out  N_MASTERS  one-hot current owner; zero when idle.
- busy  out  1  high while a burst is owned.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, busy=0, s_valid=0, s_len=0, beat counter=0.
  - Priority pointer = master 0; all m_ready=0, all m_rdata=0.
  - Applies immediately, including mid-burst. The aborted burst is not resumed; masters must reissue.
- FSM states: IDLE and BURST.
- IDLE:
  - If any m_valid is set, choose the first set bit scanning from the pointer upward with wrap (pointer, pointer+1, ..., N_MASTERS-1, 0, ...).
  - On the next edge: register grant one-hot, latch m_len of the winner into s_len, clear the beat counter, go to BURST.
  - If no m_valid is set, stay in IDLE.
  - Arbitration latency: one cycle from m_valid to grant.
- BURST:
  - Datapath is combinational from the winner: s_valid = m_valid[g]; s_addr/s_wdata/s_wstrb = winner's fields.
  - m_ready[g] = s_ready; m_rdata[g] = s_rdata. Non-granted m_ready=0 and m_rdata=0.
  - Beat = s_valid & s_ready. Each beat increments the counter (LEN_W bits).
  - A beat when counter == s_len ends the burst: next state IDLE, grant=0, pointer = g+1 (mod N_MASTERS).
  - A granted master dropping m_valid mid-burst stalls the burst; grant is held and no timeout applies.
  - Requests from other masters during BURST are ignored until IDLE.
- Bus spacing: one mandatory IDLE cycle between consecutive bursts (s_valid=0 that cycle).
- Length: len=0 is a single-beat burst. len=2^LEN_W-1 gives 2^LEN_W beats; the counter compares before incrementing and never wraps inside a burst.
- s_len holds its latched value until the next grant. m_len changes during BURST are ignored.
- Outputs while IDLE: s_valid=0; s_addr, s_wdata and s_wstrb are driven 0.
- busy = (state==BURST). grant is registered; all other outputs are combinational from grant and the inputs.

Test Plan:
- Single master 1, len=3, s_ready=1 constant: grant=3'b010 one cycle after m_valid; exactly 4 beats with m_ready[1]=1; then IDLE and pointer=2.
- All three masters request continuously, len=0: grant order 0,1,2,0,1,2, each a single beat separated by one idle cycle.
- Master 0 write burst len=7 with s_ready toggling every other cycle: 8 beats, with s_wdata/s_wstrb matching master 0 on each accept; master 2 requesting concurrently is granted only after the 8th beat.
- Read burst from master 2, len=1: s_rdata=0xA5.. appears on m_rdata[2] only; m_rdata[0] and m_rdata[1] stay 0.
- Master 1 drops m_valid for 5 cycles mid-burst: grant stays 3'b010, no beats are counted, and the burst completes with the correct total beat count afterwards.
- Assert rst=0 mid-burst (beat 2 of 8): s_valid, grant and busy drop to 0 within the same cycle; after release, the pointer is 0 and master 0 wins over simultaneous requests.
